// File: rtl/divider_seq_pkg.sv
// Shared RV32 types for the execute stage: M-extension funct3 encoding and
// the sequential divider's state encoding and op-decoding helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'b000,
    MULDIV_MULH   = 3'b001,
    MULDIV_MULHSU = 3'b010,
    MULDIV_MULHU  = 3'b011,
    MULDIV_DIV    = 3'b100,
    MULDIV_DIVU   = 3'b101,
    MULDIV_REM    = 3'b110,
    MULDIV_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [2:0] {
    DIV_IDLE    = 3'd0,
    DIV_CALC    = 3'd1,
    DIV_FIX     = 3'd2,
    DIV_SPECIAL = 3'd3,
    DIV_DONE    = 3'd4
  } div_state_t;

  function automatic logic div_is_signed(input muldiv_funct3_t op);
    return (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic div_is_rem(input muldiv_funct3_t op);
    return (op == MULDIV_REM) || (op == MULDIV_REMU);
  endfunction

endpackage

// File: rtl/divider_seq_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the widened partial remainder can take it.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    // The true difference always fits WIDTH bits when the subtract is taken.
    diff    = shifted[WIDTH-1:0] - divisor_i;
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o = diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU) with valid/ready
// on both sides, a one-cycle path for divide-by-zero/overflow, and flush.
module divider_seq
  import rv32i_types::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  muldiv_funct3_t       op,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic [WIDTH-1:0]     result
);

  // Handshake: a transfer happens on a clk edge where valid && ready are both
  // high; valid never waits on ready, and outputs hold while out_valid && !out_ready.

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t     state_q, state_d;
  muldiv_funct3_t op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

  logic accept, sgn, a_neg, b_neg, div_zero, overflow, special;
  logic [WIDTH-1:0] a_abs, b_abs, step_rem, step_quo;

  assign accept   = (state_q == DIV_IDLE) && in_valid && !flush;
  assign sgn      = div_is_signed(op);
  assign a_neg    = sgn & dividend[WIDTH-1];
  assign b_neg    = sgn & divisor[WIDTH-1];
  assign a_abs    = a_neg ? -dividend : dividend;
  assign b_abs    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign overflow = sgn && (dividend == MOST_NEG) && (divisor == '1);
  assign special  = div_zero || overflow;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      op_q        <= MULDIV_DIV;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE:    if (in_valid) state_d = special ? DIV_SPECIAL : DIV_CALC;
        DIV_CALC:    if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
        DIV_FIX:     state_d = DIV_DONE;
        DIV_SPECIAL: state_d = DIV_DONE;
        DIV_DONE:    if (out_ready) state_d = DIV_IDLE;
        default:     state_d = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    op_d        = op_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      op_d      = op;
      dz_d      = div_zero;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      rem_d     = '0;
      dvs_d     = b_abs;
      // Special cases need the raw dividend, not its magnitude.
      quo_d     = special ? dividend : a_abs;
      cnt_d     = special ? '0 : CNT_W'(WIDTH);
    end else if (state_q == DIV_CALC) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == DIV_FIX) begin
      quotient_d  = neg_quo_q ? -quo_q : quo_q;
      remainder_d = neg_rem_q ? -rem_q : rem_q;
    end else if (state_q == DIV_SPECIAL) begin
      quotient_d  = dz_q ? '1 : quo_q;
      remainder_d = dz_q ? quo_q : '0;
    end
  end

  always_comb begin
    in_ready  = (state_q == DIV_IDLE);
    out_valid = (state_q == DIV_DONE);
    quotient  = quotient_q;
    remainder = remainder_q;
    result    = div_is_rem(op_q) ? remainder_q : quotient_q;
  end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: vector table plus random ops through a scoreboard,
// hand sequences for back-pressure, flush and reset, and an 8-bit instance.
module tb_divider_seq;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  muldiv_funct3_t op = MULDIV_DIVU;
  logic [31:0] dividend = '0, divisor = '0;
  logic [31:0] quotient, remainder, result;

  divider_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .result(result)
  );

  logic flush8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic in_ready8, out_valid8;
  muldiv_funct3_t op8 = MULDIV_DIVU;
  logic [7:0] dividend8 = '0, divisor8 = '0;
  logic [7:0] quotient8, remainder8, result8;

  divider_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8),
    .out_ready(out_ready8), .quotient(quotient8), .remainder(remainder8), .result(result8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_r[$];
  logic [31:0] exp_res[$];

  typedef struct {
    muldiv_funct3_t op;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    q;
    logic [31:0]    r;
    int             lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare whenever the result handshake is about to happen.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got q=%h r=%h expected no output", quotient, remainder);
      end else begin
        check("sb_quotient", quotient, exp_q.pop_front());
        check("sb_remainder", remainder, exp_r.pop_front());
        check("sb_result", result, exp_res.pop_front());
      end
    end
  end

  task automatic push_exp(input muldiv_funct3_t o, input logic [31:0] q, input logic [31:0] r);
    exp_q.push_back(q);
    exp_r.push_back(r);
    exp_res.push_back(div_is_rem(o) ? r : q);
  endtask

  // Drive one request; returns cycles from accept edge to out_valid.
  task automatic issue(input muldiv_funct3_t o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom;
    cyc = 0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    lat = cyc;
  endtask

  task automatic run_op(input muldiv_funct3_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int exp_lat);
    int lat;
    bit busy_ok;
    push_exp(o, q, r);
    issue(o, a, b, lat, busy_ok);
    check("latency", lat, exp_lat);
    check("in_ready_busy", {31'd0, busy_ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run8(input muldiv_funct3_t o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] q, input logic [7:0] r, input int exp_lat);
    int cyc;
    op8 = o; dividend8 = a; divisor8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("w8_latency", cyc, exp_lat);
    check("w8_quotient", {24'd0, quotient8}, {24'd0, q});
    check("w8_remainder", {24'd0, remainder8}, {24'd0, r});
    check("w8_result", {24'd0, result8}, {24'd0, div_is_rem(o) ? r : q});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit seen;
    logic [31:0] a, b;
    logic signed [31:0] sa, sb;
    muldiv_funct3_t o;

    vecs[0]  = '{MULDIV_DIVU, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{MULDIV_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    vecs[2]  = '{MULDIV_REM,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
    vecs[3]  = '{MULDIV_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1};
    vecs[4]  = '{MULDIV_REMU, 32'h80000000,   32'd0,          32'hFFFFFFFF,   32'h80000000,   1};
    vecs[5]  = '{MULDIV_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1};
    vecs[6]  = '{MULDIV_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33};
    vecs[7]  = '{MULDIV_REM,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1};
    vecs[8]  = '{MULDIV_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33};
    vecs[9]  = '{MULDIV_DIV,  32'h80000000,   32'd2,          32'hC0000000,   32'd0,          33};
    vecs[10] = '{MULDIV_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   33};
    vecs[11] = '{MULDIV_DIVU, 32'd3,          32'd5,          32'd0,          32'd3,          33};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_result", result, 32'd0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 32'd1;
      case ($urandom_range(0, 3))
        0: o = MULDIV_DIV;
        1: o = MULDIV_DIVU;
        2: o = MULDIV_REM;
        default: o = MULDIV_REMU;
      endcase
      if (div_is_signed(o) && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      sa = a; sb = b;
      if (div_is_signed(o)) run_op(o, a, b, sa / sb, sa % sb, 33);
      else                  run_op(o, a, b, a / b, a % b, 33);
    end

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    push_exp(MULDIV_DIVU, 32'd10, 32'd0);
    issue(MULDIV_DIVU, 32'd50, 32'd5, lat, busy_ok);
    check("hold_latency", lat, 33);
    for (int k = 0; k < 5; k++) begin
      check("hold_quotient", quotient, 32'd10);
      check("hold_remainder", remainder, 32'd0);
      check("hold_flags", {30'd0, out_valid, in_ready}, 32'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_hs", {30'd0, out_valid, in_ready}, 32'b01);
    run_op(MULDIV_DIVU, 32'd81, 32'd9, 32'd9, 32'd0, 33);

    // A request presented together with flush must not be taken.
    op = MULDIV_DIVU; dividend = 32'd10; divisor = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {30'd0, out_valid, in_ready}, 32'b01);

    // Flush in mid-calculation.
    op = MULDIV_DIVU; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {30'd0, out_valid, in_ready}, 32'b01);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_output", {31'd0, seen}, 32'd0);
    run_op(MULDIV_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset while a result is being held clears the outputs.
    out_ready = 1'b0;
    issue(MULDIV_DIVU, 32'd77, 32'd7, lat, busy_ok);
    check("pre_rst_quotient", quotient, 32'd11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_quotient", quotient, 32'd0);
    check("mid_rst_remainder", remainder, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_flags", {30'd0, out_valid, in_ready}, 32'b01);

    run8(MULDIV_DIVU, 8'd200, 8'd9, 8'd22, 8'd2, 9);
    run8(MULDIV_DIV, 8'h80, 8'hFF, 8'h80, 8'h00, 1);
    run8(MULDIV_REM, 8'hF3, 8'd4, 8'hFD, 8'hFF, 9);

    repeat (2) @(posedge clk);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the M-extension execute stage.
- Supports the DIV, DIVU, REM and REMU operations.
- Uses valid/ready handshakes on both the request side and the result side.
- Returns RISC-V-compliant results for divide-by-zero and signed overflow through a one-cycle fast path, and can be flushed by the pipeline mid-operation.

Parameters:
WIDTH, 32, operand/result width in bits (≥4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  abandon in-flight operation (pipeline squash)
in_valid  in  1  request valid
in_ready  out  1  divider can accept a request
op  in  3  muldiv_funct3_t: div, divu, rem, remu
dividend  in  WIDTH  numerator
divisor  in  WIDTH  denominator
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  WIDTH  final signed/unsigned quotient
remainder  out  WIDTH  final signed/unsigned remainder
result  out  WIDTH  quotient for div/divu, remainder for rem/remu

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, result=0, counter=0.
- States:
  - IDLE: in_ready=1. On in_valid && !flush, latch op, sign flags and absolute operands.
    - divisor==0 or signed overflow → SPECIAL.
    - Otherwise → CALC with counter=WIDTH, partial remainder=0.
  - CALC: each cycle, shift {rem, quo} left by 1 and bring in the MSB of the remaining dividend. If shifted rem ≥ |divisor|, subtract it and set the quotient LSB to 1. Decrement counter. At counter==1 → FIX.
  - FIX: apply signs.
    - Quotient is negated when dividend_sign ^ divisor_sign (signed ops only).
    - Remainder is negated when dividend_sign (signed ops only).
    - Outputs are registered; → DONE.
  - SPECIAL: load special results; → DONE.
  - DONE: out_valid=1 and outputs held stable until out_ready. On out_valid && out_ready → IDLE. in_ready=0.
- Latency (accept edge to out_valid high):
  - Normal: WIDTH+1 cycles.
  - Special case: 1 cycle.
- Throughput: one operation in flight. Back-to-back operation is accepted the cycle after the result handshake (in_ready rises in IDLE).
- Special results:
  - divisor==0: quotient = all ones, remainder = dividend (unmodified, any op).
  - Signed overflow (div/rem, dividend = 1<<(WIDTH-1), divisor = all ones): quotient = dividend, remainder = 0.
- Unsigned ops: operands are used unmodified; sign flags are forced to 0.
- Absolute value: two's complement of the most-negative value is itself and is treated as unsigned magnitude (correct because computation is unsigned WIDTH-bit).
- flush: highest priority in every state. Next state IDLE, out_valid=0 next cycle, partial results discarded. A request presented with flush=1 is not accepted.
- rst mid-operation: identical to flush, plus all outputs cleared.
- Inputs op/dividend/divisor need only be stable on the accept cycle.
- result mux is combinational from registered quotient/remainder and latched op.
- No X on outputs in any state.

Decomposition:
- rv32i_types (existing package) supplies muldiv_funct3_t.
- Add div_state_t (IDLE, CALC, FIX, SPECIAL, DONE) to rv32i_types.
- Add helper function div_is_signed(op) to rv32i_types.
- Sub-module div_restore_step: combinational, WIDTH-parametrised single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside the CALC datapath.

Test Plan:
- divu 100/7, out_ready=1 → quotient=14, remainder=2, out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- div 0xFFFFFFF9 (-7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; rem 7 / 0xFFFFFFFE → result=1.
- div 5/0 → quotient=0xFFFFFFFF, remainder=5, out_valid 1 cycle after accept; remu 0x80000000/0 → result=0x80000000.
- div 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, 1-cycle latency; divu same operands → quotient=0, remainder=0x80000000 via CALC.
- Hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0; raise out_ready → IDLE next cycle, second request accepted immediately after.
- Assert flush 10 cycles into divu 1000/3 → no out_valid ever for it, in_ready=1 next cycle; new divu 9/3 yields quotient=3, remainder=0. Repeat with WIDTH=8: divu 200/9 → quotient=22, remainder=2, latency 9.
